avl_mem_responder: RTL and testbench
====================================

AVL_MEM_RESPONDER -- requirements
Module: avl_mem_responder

Interface
REQ-001 Parameter AW, default 32: word-address width.
REQ-002 Parameter DW, default 32: data width; a multiple of 8.
REQ-003 Parameter DEPTH, default 2048: number of DW-bit words stored.
REQ-004 Parameter RD_LATENCY, default 2: cycles from read acceptance to readdatavalid; legal range 1..8.
REQ-005 Parameter MAX_PENDING, default 4: maximum number of accepted reads not yet returned; at least 1.
REQ-006 clk  in  1  system clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous reset, active-high.
REQ-008 address  in  AW  word address of the current request.
REQ-009 read  in  1  read request.
REQ-010 write  in  1  write request.
REQ-011 writedata  in  DW  write data.
REQ-012 byteenable  in  DW/8  per-byte write enable.
REQ-013 waitrequest  out  1  high means the request is not accepted this cycle.
REQ-014 readdata  out  DW  read return data.
REQ-015 readdatavalid  out  1  one-cycle qualifier for readdata.
REQ-016 rd_count  out  32  number of reads accepted since reset.
REQ-017 wr_count  out  32  number of writes accepted since reset.
REQ-018 err  out  1  sticky protocol/range error flag.

Function
REQ-019 FSM states are INIT and READY: reset enters INIT, INIT moves to READY unconditionally on the next clk edge, and READY is held until reset.
REQ-020 waitrequest = 1 in INIT; in READY, waitrequest = 1 when pending == MAX_PENDING, otherwise 0.
REQ-021 waitrequest is decoded from registered state only and has no combinational path from read, write or address.
REQ-022 A read is accepted in any cycle with read=1, write=0 and waitrequest=0.
REQ-023 A write is accepted in any cycle with write=1 and waitrequest=0.
REQ-024 An accepted read of address A produces readdatavalid=1 with readdata=mem[A] exactly RD_LATENCY cycles after acceptance.
REQ-025 Reads are pipelined: back-to-back accepted reads return on consecutive cycles, in order, with no bubbles.
REQ-026 An accepted write updates mem[address] only for bytes whose byteenable bit is 1; bytes with byteenable=0 keep their old value.
REQ-027 A write is visible to a read accepted in the following cycle or later.
REQ-028 read=1 and write=1 in the same cycle: the write is performed, the read is dropped (no return, no pending increment), and err is set.
REQ-029 An accepted write with address >= DEPTH is discarded and sets err.
REQ-030 An accepted read with address >= DEPTH returns readdata = 0 with normal latency and sets err.
REQ-031 pending: +1 on read acceptance, -1 on readdatavalid, unchanged when both occur in the same cycle, never exceeds MAX_PENDING.
REQ-032 readdata holds its last value while readdatavalid=0.
REQ-033 rd_count and wr_count increment by 1 per accepted read or write respectively and wrap modulo 2^32.
REQ-034 err, once set, stays at 1 until reset.

Reset
REQ-035 Reset drives waitrequest=1, readdatavalid=0, readdata=0, rd_count=0, wr_count=0, err=0 and pending=0, and flushes the read-return pipeline.
REQ-036 Reset asserted mid-operation discards all in-flight reads: no readdatavalid is produced after reset release for requests accepted before it.
REQ-037 Memory contents are not cleared by reset.

Verification
REQ-038 Write 0xDEADBEEF to address 5 with byteenable=0xF, then read address 5 -> readdatavalid exactly 2 cycles after acceptance with readdata=0xDEADBEEF; wr_count=1, rd_count=1.
REQ-039 mem[7]=0x11223344, then write 0xAABBCCDD to address 7 with byteenable=0x5, then read address 7 -> readdata=0x11BB33DD.
REQ-040 Hold read=1 on addresses 0..9 with MAX_PENDING=4 and RD_LATENCY=2 -> reads return in order as 0..9 with no drops, pending never exceeds 4, and waitrequest asserts whenever pending==4.
REQ-041 Assert read=1 and write=1 together to address 3 with data 0x55 -> mem[3]=0x55, no readdatavalid for that cycle, err=1 and stays 1.
REQ-042 Read address DEPTH+1 -> readdata=0 after 2 cycles, err=1; write to DEPTH -> memory unchanged, wr_count increments.
REQ-043 Accept 3 reads, then pulse rst before any return -> readdatavalid never asserts for them; waitrequest=1 for 1 cycle after release, then 0; rd_count=0.

Source files
------------

// File: rtl/avl_mem_responder.sv
// ---------------------------------------------------------------------------
// avl_mem_responder
//
// Avalon-MM style memory slave with pipelined reads of fixed latency.
// Holds DEPTH words of DW bits. Reads return RD_LATENCY cycles after
// acceptance, in order and without bubbles. Writes honour byteenable.
// At most MAX_PENDING reads may be outstanding; beyond that the slave
// stalls the master with waitrequest.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active high
//   address        word address of the current request (AW bits)
//   read, write    request strobes
//   writedata      write data (DW bits)
//   byteenable     per-byte write enable (DW/8 bits)
//   waitrequest    1 = request not accepted this cycle (registered)
//   readdata       read return data, holds while readdatavalid = 0
//   readdatavalid  one-cycle qualifier for readdata
//   rd_count       reads accepted since reset (wraps)
//   wr_count       writes accepted since reset (wraps)
//   err            sticky error: read/write collision or out-of-range access
// ---------------------------------------------------------------------------
module avl_mem_responder #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH       = 2048,
  parameter int RD_LATENCY  = 2,
  parameter int MAX_PENDING = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   address,
  input  logic            read,
  input  logic            write,
  input  logic [DW-1:0]   writedata,
  input  logic [DW/8-1:0] byteenable,
  output logic            waitrequest,
  output logic [DW-1:0]   readdata,
  output logic            readdatavalid,
  output logic [31:0]     rd_count,
  output logic [31:0]     wr_count,
  output logic            err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int NB = DW / 8;
  localparam logic [PW-1:0] MAX_PND   = PW'(MAX_PENDING);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  typedef enum logic {INIT, READY} state_t;

  state_t          state;
  logic [PW-1:0]   pending;
  logic [PW-1:0]   pending_next;
  logic            rd_accept;
  logic            wr_accept;
  logic            collision;
  logic            in_range;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   rd_word;

  logic [DW-1:0]         mem [DEPTH];
  logic [RD_LATENCY-1:0] valid_pipe;
  logic [DW-1:0]         data_pipe [RD_LATENCY];
  logic [RD_LATENCY-1:0] valid_in;
  logic [DW-1:0]         data_in [RD_LATENCY];

  assign in_range  = ({1'b0, address} < DEPTH_EXT);
  assign idx       = address[IW-1:0];
  // A simultaneous read+write is treated as a write; the read is dropped.
  assign rd_accept = read & ~write & ~waitrequest;
  assign wr_accept = write & ~waitrequest;
  assign collision = read & write & ~waitrequest;
  assign rd_word   = in_range ? mem[idx] : '0;

  assign readdatavalid = valid_pipe[RD_LATENCY-1];
  assign readdata      = data_pipe[RD_LATENCY-1];

  // Outstanding-read count after this edge: a return and a new acceptance
  // in the same cycle cancel out.
  always_comb begin
    pending_next = pending;
    if (rd_accept && !readdatavalid)
      pending_next = pending + PW'(1);
    else if (!rd_accept && readdatavalid)
      pending_next = pending - PW'(1);
  end

  // Control FSM. waitrequest is registered from the next-cycle pending count,
  // so it never depends combinationally on read/write/address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      waitrequest <= 1'b1;
      pending     <= '0;
      rd_count    <= '0;
      wr_count    <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          state       <= READY;
          waitrequest <= 1'b0;
        end
        READY: begin
          state       <= READY;
          waitrequest <= (pending_next == MAX_PND);
        end
        default: begin
          state       <= INIT;
          waitrequest <= 1'b1;
        end
      endcase
      pending <= pending_next;
      if (rd_accept)
        rd_count <= rd_count + 32'd1;
      if (wr_accept)
        wr_count <= wr_count + 32'd1;
      if (collision || ((rd_accept || wr_accept) && !in_range))
        err <= 1'b1;
    end
  end

  // Stage inputs of the read-return pipeline; stage 0 captures the memory
  // word at acceptance so later writes cannot alter an accepted read.
  always_comb begin
    valid_in[0] = rd_accept;
    data_in[0]  = rd_word;
    for (int i = 1; i < RD_LATENCY; i++) begin
      valid_in[i] = valid_pipe[i-1];
      data_in[i]  = data_pipe[i-1];
    end
  end

  // The last stage only loads on a valid beat so readdata holds between
  // returns; inner stages shift freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++)
        data_pipe[i] <= '0;
    end else begin
      valid_pipe <= valid_in;
      for (int i = 0; i < RD_LATENCY; i++) begin
        if (valid_in[i] || (i != RD_LATENCY - 1))
          data_pipe[i] <= data_in[i];
      end
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_accept && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (byteenable[b])
          mem[idx][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_avl_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_avl_mem_responder
//
// Self-checking bench for avl_mem_responder. A cycle model sampled on the
// falling edge keeps a scoreboard of expected read returns, a shadow memory,
// the outstanding-read count, counters and the error flag, and compares them
// with the DUT every cycle. A linear sequence of directed steps drives the
// main instance (default parameters); a second instance with MAX_PENDING=1
// and RD_LATENCY=3 exercises back-pressure.
// ---------------------------------------------------------------------------
module tb_avl_mem_responder;

  localparam int L     = 2;
  localparam int MAXP  = 4;
  localparam int DEPTH = 2048;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic        err;

  logic        bp_read;
  logic        bp_write;
  logic        bp_waitrequest;
  logic [31:0] bp_readdata;
  logic        bp_readdatavalid;
  logic [31:0] bp_rd_count;
  logic [31:0] bp_wr_count;
  logic        bp_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl_mem [DEPTH];
  int          mdl_pending;
  logic [31:0] mdl_rdcnt;
  logic [31:0] mdl_wrcnt;
  logic        mdl_err;
  logic [31:0] mdl_rdata;
  bit          mdl_init;
  bit          exp_wait;
  bit          exp_rdv;
  bit          acc_r;
  bit          acc_w;

  avl_mem_responder #(
    .AW(32), .DW(32), .DEPTH(DEPTH), .RD_LATENCY(L), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid), .rd_count(rd_count),
    .wr_count(wr_count), .err(err)
  );

  avl_mem_responder #(
    .AW(8), .DW(32), .DEPTH(16), .RD_LATENCY(3), .MAX_PENDING(1)
  ) dut_bp (
    .clk(clk), .rst(rst), .address(address[7:0]), .read(bp_read),
    .write(bp_write), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(bp_waitrequest), .readdata(bp_readdata),
    .readdatavalid(bp_readdatavalid), .rd_count(bp_rd_count),
    .wr_count(bp_wr_count), .err(bp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr,
                               input logic [31:0] wdata,
                               input logic [3:0] be);
    @(posedge clk);
    #1;
    read       = rd;
    write      = wr;
    address    = addr;
    writedata  = wdata;
    byteenable = be;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst   = 1'b1;
    read  = 1'b0;
    write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] fillValue(input int a);
    return 32'h1000_0000 + 32'(a) * 32'h0000_0101;
  endfunction

  // Cycle model of the main instance, evaluated mid-cycle while inputs and
  // registered outputs are stable.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mdl_pending = 0;
      mdl_rdcnt   = '0;
      mdl_wrcnt   = '0;
      mdl_err     = 1'b0;
      mdl_rdata   = '0;
      mdl_init    = 1'b1;
      checkOutput("rst_waitrequest", waitrequest, 1);
      checkOutput("rst_readdatavalid", readdatavalid, 0);
      checkOutput("rst_readdata", readdata, 0);
      checkOutput("rst_rd_count", rd_count, 0);
      checkOutput("rst_wr_count", wr_count, 0);
      checkOutput("rst_err", err, 0);
    end else begin
      exp_wait = mdl_init || (mdl_pending == MAXP);
      exp_rdv  = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      if (exp_rdv) begin
        mdl_rdata = exp_q[0].data;
        void'(exp_q.pop_front());
      end
      checkOutput("waitrequest", waitrequest, exp_wait);
      checkOutput("readdatavalid", readdatavalid, exp_rdv);
      checkOutput("readdata", readdata, mdl_rdata);
      checkOutput("rd_count", rd_count, mdl_rdcnt);
      checkOutput("wr_count", wr_count, mdl_wrcnt);
      checkOutput("err", err, mdl_err);

      mdl_init = 1'b0;
      acc_r = read && !write && !exp_wait;
      acc_w = write && !exp_wait;
      if (acc_r) begin
        exp_q.push_back('{data: (address < DEPTH) ? mdl_mem[address[10:0]] : 32'h0,
                          due: cyc + L});
        mdl_rdcnt = mdl_rdcnt + 32'd1;
        if (address >= DEPTH) mdl_err = 1'b1;
      end
      if (acc_w) begin
        mdl_wrcnt = mdl_wrcnt + 32'd1;
        if (read) mdl_err = 1'b1;
        if (address < DEPTH) begin
          for (int b = 0; b < 4; b++)
            if (byteenable[b]) mdl_mem[address[10:0]][8*b +: 8] = writedata[8*b +: 8];
        end else begin
          mdl_err = 1'b1;
        end
      end
      if (acc_r && !exp_rdv) mdl_pending++;
      else if (!acc_r && exp_rdv) mdl_pending--;
    end
  end

  initial begin
    int budget;
    rst        = 1'b1;
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    writedata  = '0;
    byteenable = '0;
    bp_read    = 1'b0;
    bp_write   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("init_waitrequest", waitrequest, 1);
    @(negedge clk);
    checkOutput("ready_waitrequest", waitrequest, 0);

    // Back-pressure instance: one outstanding read, latency 3, so with read
    // held high one read is accepted every fourth cycle.
    $display("[TB] back-pressure instance");
    @(posedge clk);
    #1;
    bp_write   = 1'b1;
    address    = 32'd0;
    writedata  = 32'h0BAD_CAFE;
    byteenable = 4'hF;
    @(posedge clk);
    #1;
    bp_write = 1'b0;
    bp_read  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("bp_waitrequest", bp_waitrequest, (i % 4) != 0);
      checkOutput("bp_readdatavalid", bp_readdatavalid, (i % 4) == 3);
      if ((i % 4) == 3) checkOutput("bp_readdata", bp_readdata, 32'h0BAD_CAFE);
    end
    @(posedge clk);
    #1;
    bp_read = 1'b0;
    @(negedge clk);
    checkOutput("bp_rd_count", bp_rd_count, 3);
    checkOutput("bp_wr_count", bp_wr_count, 1);
    checkOutput("bp_err", bp_err, 0);

    // Write then read address 5: return exactly two cycles after acceptance.
    $display("[TB] write/read address 5");
    applyStimulus(0, 1, 32'd5, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(1, 0, 32'd5, 32'h0, 4'h0);
    applyStimulus(0, 0, 32'd0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rd5_latency_early", readdatavalid, 0);
    @(negedge clk);
    checkOutput("rd5_valid", readdatavalid, 1);
    checkOutput("rd5_data", readdata, 32'hDEAD_BEEF);
    checkOutput("rd5_rd_count", rd_count, 1);
    checkOutput("rd5_wr_count", wr_count, 1);

    // Partial byte write merges with the old word.
    $display("[TB] byteenable merge at address 7");
    applyStimulus(0, 1, 32'd7, 32'h1122_3344, 4'hF);
    applyStimulus(0, 1, 32'd7, 32'hAABB_CCDD, 4'h5);
    applyStimulus(1, 0, 32'd7, 32'h0, 4'h0);
    applyStimulus(0, 0, 32'd0, 32'h0, 4'h0);
    applyStimulus(0, 0, 32'd0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rd7_valid", readdatavalid, 1);
    checkOutput("rd7_merged", readdata, 32'h11BB_33DD);
    @(negedge clk);
    checkOutput("rd7_hold", readdata, 32'h11BB_33DD);

    // Streaming reads 0..9 with read held high.
    $display("[TB] streaming reads 0..9");
    for (int a = 0; a < 10; a++)
      applyStimulus(0, 1, 32'(a), fillValue(a), 4'hF);
    for (int a = 0; a < 10; a++) begin
      applyStimulus(1, 0, 32'(a), 32'h0, 4'h0);
      budget = 0;
      while (waitrequest && budget < 20) begin
        @(posedge clk);
        #1;
        budget++;
      end
      checkOutput("stream_accept", waitrequest, 0);
    end
    applyStimulus(0, 0, 32'd0, 32'h0, 4'h0);
    repeat (4) @(negedge clk);
    checkOutput("stream_last_data", readdata, fillValue(9));
    checkOutput("stream_rd_count", rd_count, 12);

    // Out-of-range read returns zero and flags err.
    $display("[TB] out-of-range read");
    checkOutput("oor_err_before", err, 0);
    applyStimulus(1, 0, DEPTH + 1, 32'h0, 4'h0);
    applyStimulus(0, 0, 32'd0, 32'h0, 4'h0);
    applyStimulus(0, 0, 32'd0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("oor_rd_valid", readdatavalid, 1);
    checkOutput("oor_rd_data", readdata, 0);
    checkOutput("oor_rd_err", err, 1);

    // Out-of-range write is discarded (no aliasing onto word 0), still counted.
    doReset();
    @(negedge clk);
    checkOutput("reset_err_cleared", err, 0);
    applyStimulus(0, 1, DEPTH, 32'hCAFE_F00D, 4'hF);
    applyStimulus(1, 0, 32'd0, 32'h0, 4'h0);
    applyStimulus(0, 0, 32'd0, 32'h0, 4'h0);
    applyStimulus(0, 0, 32'd0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("oor_wr_mem0", readdata, fillValue(0));
    checkOutput("oor_wr_count", wr_count, 1);
    checkOutput("oor_wr_err", err, 1);

    // Simultaneous read and write: write wins, read dropped, err sticky.
    $display("[TB] read/write collision");
    doReset();
    applyStimulus(1, 1, 32'd3, 32'h0000_0055, 4'hF);
    applyStimulus(0, 0, 32'd0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("coll_err", err, 1);
    checkOutput("coll_rd_count", rd_count, 0);
    @(negedge clk);
    checkOutput("coll_no_return", readdatavalid, 0);
    applyStimulus(1, 0, 32'd3, 32'h0, 4'h0);
    applyStimulus(0, 0, 32'd0, 32'h0, 4'h0);
    applyStimulus(0, 0, 32'd0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("coll_mem3", readdata, 32'h0000_0055);
    checkOutput("coll_wr_count", wr_count, 1);
    repeat (3) @(negedge clk);
    checkOutput("coll_err_sticky", err, 1);

    // Reset mid-flight: in-flight reads never return after release.
    $display("[TB] reset with reads in flight");
    applyStimulus(1, 0, 32'd0, 32'h0, 4'h0);
    applyStimulus(1, 0, 32'd1, 32'h0, 4'h0);
    applyStimulus(1, 0, 32'd2, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("flush_wait_init", waitrequest, 1);
    checkOutput("flush_rd_count", rd_count, 0);
    @(negedge clk);
    checkOutput("flush_wait_ready", waitrequest, 0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("flush_no_return", readdatavalid, 0);
      @(negedge clk);
    end
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
